// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared op codes and FSM encoding for the RV32M multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex_muldiv_sequencer_pkg;

  localparam int MD_OP_WIDTH = 3;

  localparam logic [MD_OP_WIDTH-1:0] MD_MUL    = 3'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULH   = 3'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULHSU = 3'd2;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULHU  = 3'd3;
  localparam logic [MD_OP_WIDTH-1:0] MD_DIV    = 3'd4;
  localparam logic [MD_OP_WIDTH-1:0] MD_DIVU   = 3'd5;
  localparam logic [MD_OP_WIDTH-1:0] MD_REM    = 3'd6;
  localparam logic [MD_OP_WIDTH-1:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_sequencer_md_iter.sv
// Single iteration of shift-add multiply or restoring divide on unsigned magnitudes.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the step is committed.
module md_iter_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] acc_cur,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  logic                    is_div,
  output logic [2*DATA_WIDTH-1:0] acc_next,
  output logic                    q_bit
);

  localparam int W = DATA_WIDTH;

  logic [W:0] mul_sum;
  logic [W:0] div_shift;
  logic [W:0] div_trial;
  logic       div_fits;

  // Multiply: {hi, multiplier} shifts right, hi accumulates the multiplicand.
  // Divide: {remainder, dividend} shifts left; the quotient bit is reported
  // separately and lands in the vacated LSB inside the sequencer.
  always_comb begin
    mul_sum   = {1'b0, acc_cur[2*W-1:W]} + (acc_cur[0] ? {1'b0, operand} : '0);
    div_shift = {acc_cur[2*W-1:W], acc_cur[W-1]};
    div_trial = div_shift - {1'b0, operand};
    div_fits  = ~div_trial[W];
    if (is_div) begin
      acc_next = {(div_fits ? div_trial[W-1:0] : div_shift[W-1:0]), acc_cur[W-2:0], 1'b0};
      q_bit    = div_fits;
    end else begin
      acc_next = {mul_sum, acc_cur[W-1:1]};
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage RV32M sequencer: captures operands, iterates 32 steps, presents the result.
// Latency: 33 cycles after accept (DATA_WIDTH+1), 1 cycle for divide-by-zero/overflow.
// Backpressure: EX_MdStall holds the front of the pipe from accept until the result cycle.
module ex_muldiv_sequencer
  import ex_muldiv_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   IDEX_MdEN,
  input  logic [MD_OP_WIDTH-1:0] IDEX_MdOp,
  input  logic [DATA_WIDTH-1:0]  forward_rs1,
  input  logic [DATA_WIDTH-1:0]  forward_rs2,
  input  logic                   EX_Flush,
  output logic                   EX_MdStall,
  output logic                   EX_MdValid,
  output logic [DATA_WIDTH-1:0]  EX_MdData
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [W-1:0]     SMIN     = {1'b1, {(W-1){1'b0}}};

  md_state_e              state_q, state_d;
  logic [MD_OP_WIDTH-1:0] op_q;
  logic [W-1:0]           opnd_q;
  logic [2*W-1:0]         acc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   neg_q;
  logic [W-1:0]           data_q;

  logic           in_div, in_rem, rs1_sgn, rs2_sgn, rs1_neg, rs2_neg, res_neg;
  logic           div_zero, div_ovf, fast;
  logic [W-1:0]   abs1, abs2, fast_res;
  logic           accept, step, last;
  logic [2*W-1:0] iter_acc, acc_step, prod_fix;
  logic           iter_q;
  logic [W-1:0]   quo, rmd, calc_res;

  // Decode the op waiting in IDEX: magnitudes, result sign and fast-path result.
  always_comb begin
    in_div   = IDEX_MdOp[2];
    in_rem   = IDEX_MdOp[2] & IDEX_MdOp[1];
    rs1_sgn  = (IDEX_MdOp == MD_MULH) | (IDEX_MdOp == MD_MULHSU) |
               (IDEX_MdOp == MD_DIV)  | (IDEX_MdOp == MD_REM);
    rs2_sgn  = (IDEX_MdOp == MD_MULH) | (IDEX_MdOp == MD_DIV) | (IDEX_MdOp == MD_REM);
    rs1_neg  = rs1_sgn & forward_rs1[W-1];
    rs2_neg  = rs2_sgn & forward_rs2[W-1];
    abs1     = rs1_neg ? (~forward_rs1 + 1'b1) : forward_rs1;
    abs2     = rs2_neg ? (~forward_rs2 + 1'b1) : forward_rs2;
    res_neg  = in_rem ? rs1_neg : (rs1_neg ^ rs2_neg);
    div_zero = in_div & (forward_rs2 == '0);
    div_ovf  = in_div & ~IDEX_MdOp[0] & (forward_rs1 == SMIN) & (forward_rs2 == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = in_rem ? forward_rs1 : '1;
    else          fast_res = in_rem ? '0 : SMIN;
  end

  assign accept = (state_q == MD_IDLE) & IDEX_MdEN & ~EX_Flush;
  assign step   = (state_q == MD_CALC) & ~EX_Flush;
  assign last   = (cnt_q == '0);

  md_iter_unit #(.DATA_WIDTH(W)) u_iter (
    .acc_cur  (acc_q),
    .operand  (opnd_q),
    .is_div   (op_q[2]),
    .acc_next (iter_acc),
    .q_bit    (iter_q)
  );

  // Merge the quotient bit, then sign-correct the finished value for the last step.
  always_comb begin
    acc_step = iter_acc | {{(2*W-1){1'b0}}, iter_q};
    prod_fix = neg_q ? (~acc_step + 1'b1) : acc_step;
    quo      = acc_step[W-1:0];
    rmd      = acc_step[2*W-1:W];
    case (op_q)
      MD_MUL:                       calc_res = prod_fix[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: calc_res = prod_fix[2*W-1:W];
      MD_DIV, MD_DIVU:              calc_res = neg_q ? (~quo + 1'b1) : quo;
      default:                      calc_res = neg_q ? (~rmd + 1'b1) : rmd;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  // Next state; a flush always wins, DONE ignores IDEX_MdEN since the op is still in IDEX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (IDEX_MdEN) state_d = fast ? MD_DONE : MD_CALC;
      MD_CALC: if (last)      state_d = MD_DONE;
      MD_DONE:                state_d = MD_IDLE;
      default:                state_d = MD_IDLE;
    endcase
    if (EX_Flush) state_d = MD_IDLE;
  end

  // Operand capture, iteration and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= MD_MUL;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= IDEX_MdOp;
      opnd_q <= in_div ? abs2 : abs1;
      acc_q  <= {{W{1'b0}}, (in_div ? abs1 : abs2)};
      cnt_q  <= CNT_INIT;
      neg_q  <= res_neg;
      if (fast) data_q <= fast_res;
    end else if (step) begin
      acc_q <= acc_step;
      if (last) data_q <= calc_res;
      else      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign EX_MdStall = accept | (state_q == MD_CALC);
  assign EX_MdValid = (state_q == MD_DONE);
  assign EX_MdData  = data_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench: directed RV32M cases plus randomized ops against an arithmetic model.
// Latency: checks 33-cycle stall on the full path, 1 cycle on divide fast paths.
// Backpressure: holds IDEX inputs steady while EX_MdStall is high.
module tb_ex_muldiv_sequencer;

  localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3;
  localparam int OP_DIV = 4, OP_DIVU = 5, OP_REM = 6, OP_REMU = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_en;
  logic [2:0]  md_op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        stall, valid;
  logic [31:0] data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IDEX_MdEN   (md_en),
    .IDEX_MdOp   (md_op),
    .forward_rs1 (rs1),
    .forward_rs2 (rs2),
    .EX_Flush    (flush),
    .EX_MdStall  (stall),
    .EX_MdValid  (valid),
    .EX_MdData   (data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // RV32M result from 64-bit signed arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] ref_md(input int op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MUL:    begin p = ua * ub; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      OP_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      OP_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_stall(input int op, input logic [31:0] a, input logic [31:0] b);
    if (op >= OP_DIV && b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called one step after a rising edge with the sequencer idle; returns the same way.
  task automatic run_op(input string tag, input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          n;
    logic        early_vld;
    exp   = ref_md(op, a, b);
    md_en = 1'b1;
    md_op = op[2:0];
    rs1   = a;
    rs2   = b;
    #1;
    n = 0;
    early_vld = 1'b0;
    while (stall === 1'b1 && n < 100) begin
      if (valid !== 1'b0) early_vld = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    chk({tag, "_stall_cycles"}, n, ref_stall(op, a, b));
    chk({tag, "_vld_early"}, {31'd0, early_vld}, 32'd0);
    chk({tag, "_vld"}, {31'd0, valid}, 32'd1);
    chk({tag, "_dat"}, data, exp);
    md_en = 1'b0;
    rs1   = $urandom;
    rs2   = $urandom;
    @(posedge clk); #1;
    chk({tag, "_vld_off"}, {31'd0, valid}, 32'd0);
    chk({tag, "_dat_hold"}, data, exp);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic saw_vld;
    rst_n = 1'b0;
    md_en = 1'b0;
    md_op = 3'd0;
    rs1   = '0;
    rs2   = '0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_vld", {31'd0, valid}, 32'd0);
    chk("reset_dat", data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_neg3",   OP_MUL,    32'd7,          32'hFFFF_FFFD);
    run_op("mulhu_max",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("mulhsu_max", OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("mulh_neg",   OP_MULH,   32'h8000_0000,  32'h8000_0000);
    run_op("div_neg7",   OP_DIV,    32'hFFFF_FFF9,  32'd2);
    run_op("rem_neg7",   OP_REM,    32'hFFFF_FFF9,  32'd2);
    run_op("divu_zero",  OP_DIVU,   32'h0000_1234,  32'd0);
    run_op("remu_zero",  OP_REMU,   32'h0000_1234,  32'd0);
    run_op("div_ovf",    OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
    run_op("rem_ovf",    OP_REM,    32'h8000_0000,  32'hFFFF_FFFF);
    run_op("divu_big",   OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF);

    // Flush mid-calculation: no result, pipeline released the next cycle.
    md_en = 1'b1; md_op = 3'(OP_MUL); rs1 = $urandom; rs2 = $urandom;
    #1;
    saw_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (valid !== 1'b0) saw_vld = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1;
    chk("flush_calc_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    md_en = 1'b0;
    #1;
    chk("flush_stall_drop", {31'd0, stall}, 32'd0);
    chk("flush_no_vld", {31'd0, valid | saw_vld}, 32'd0);
    run_op("divu_after_flush", OP_DIVU, 32'd100, 32'd7);

    // Flush coinciding with acceptance: the op is dropped.
    md_en = 1'b1; md_op = 3'(OP_DIVU); rs1 = 32'd50; rs2 = 32'd0; flush = 1'b1;
    #1;
    chk("flush_accept_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    md_en = 1'b0;
    #1;
    chk("flush_accept_vld", {31'd0, valid}, 32'd0);
    chk("flush_accept_idle", {31'd0, stall}, 32'd0);

    // Reset mid-calculation.
    md_en = 1'b1; md_op = 3'(OP_DIV); rs1 = $urandom; rs2 = 32'd3;
    #1;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    md_en = 1'b0;
    #1;
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_vld", {31'd0, valid}, 32'd0);
    chk("rst_mid_dat", data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("rem_after_rst", OP_REM, 32'd100, 32'hFFFF_FFF9);

    for (int k = 0; k < 40; k++) begin
      int          op;
      logic [31:0] a, b;
      op = $urandom_range(0, 7);
      a  = pick_val();
      b  = pick_val();
      run_op($sformatf("rnd%0d_op%0d", k, op), op, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_sequencer.md
# ex_muldiv_sequencer

Multi-cycle sequencer for RV32M multiply/divide in the EX stage, alongside the single-cycle ALU input/output dispatcher. It captures forwarded rs1/rs2 when an M-extension op is in IDEX and runs an iterative shift-add multiply or restoring divide over 32 cycles. It stalls the pipeline while busy and presents a registered result for one cycle so the EX result mux can select it in place of the ALU result.

## Interface
- `DATA_WIDTH`, default 32: operand and result width. Counter width is derived as clog2(DATA_WIDTH)+1.
- `clk` input 1: core clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `IDEX_MdEN` input 1: the IDEX instruction is an M-extension op.
- `IDEX_MdOp` input 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `forward_rs1` input DATA_WIDTH: forwarded rs1 value.
- `forward_rs2` input DATA_WIDTH: forwarded rs2 value.
- `EX_Flush` input 1: kill the in-flight op (branch or trap flush).
- `EX_MdStall` output 1: hold IF/ID/IDEX, combinational.
- `EX_MdValid` output 1: `EX_MdData` is valid this cycle; selects the M result into `EX_AluData`.
- `EX_MdData` output DATA_WIDTH: result, registered.

## Operation
- States:
  - IDLE: no op in flight.
  - CALC: iterating; a 6-bit counter counts down from 31.
  - DONE: result held for one cycle.
- IDLE → CALC when `IDEX_MdEN`=1 and the op is not a fast-path case. The block latches the op, |rs1|, |rs2| (per-op signedness), the result sign and the counter.
- IDLE → DONE directly (fast path) in two cases:
  - DIV/DIVU/REM/REMU with rs2=0: quotient = all ones; remainder = rs1.
  - DIV/REM with rs1=0x8000_0000 and rs2=0xFFFF_FFFF: quotient = 0x8000_0000; remainder = 0.
- CALC, one step per cycle:
  - Multiply: 64-bit accumulator, shift-add on the low multiplier bit.
  - Divide: restoring step; shift remainder left, trial-subtract the divisor, set the quotient bit.
- CALC → DONE when the counter reaches 0 after the step. The sign fix-up (two's-complement negate) is applied on the DONE entry edge.
- DONE → IDLE unconditionally. `IDEX_MdEN` is ignored in DONE, because the same instruction is still in IDEX.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- `EX_Flush` in any state → IDLE next cycle. No valid is produced and the flushed op is not restarted. Flush has priority over acceptance in the same cycle.
- `rst_n`=0 at any clock edge (including mid-CALC) → IDLE.
- Reset values:
  - `EX_MdData` = 0.
  - `EX_MdValid` = 0.
  - Counter = 0.
  - `EX_MdStall` = 0, because it is combinational from IDLE with `IDEX_MdEN` low.

## Timing
- Cycle A is the accept cycle: IDLE with `IDEX_MdEN`=1.
- Full path:
  - CALC occupies A+1..A+32; DONE is A+33.
  - `EX_MdStall`=1 in cycles A..A+32 (33 cycles).
  - `EX_MdValid`=1 only in A+33; `EX_MdStall`=0 in A+33, so IDEX advances at the end of A+33.
- Fast path: `EX_MdStall`=1 in A only; DONE and valid in A+1.
- `EX_MdStall` = (IDLE & `IDEX_MdEN` & ~`EX_Flush`) | CALC.
- Back-to-back M ops: the second is accepted in the IDLE cycle after DONE (A+34). There is no dead cycle beyond that.
- `EX_MdData` holds its last value outside DONE. Consumers must qualify it with `EX_MdValid`.

## Structure
- `Define.v` gains:
  - `MD_OP_WIDTH` and the eight `MD_*` op codes.
  - `MD_IDLE`/`MD_CALC`/`MD_DONE` state encodings (2 bits).
- One natural sub-module: `md_iter_unit`, the combinational single-step datapath. It takes accumulator/remainder, operand and mode, and produces the next accumulator/remainder and quotient bit. The sequencer owns all registers, the FSM and the sign fix-up.

## Test plan
- MUL rs1=7, rs2=0xFFFF_FFFD:
  - `EX_MdStall` is high exactly 33 cycles.
  - Then `EX_MdValid`=1 for 1 cycle with `EX_MdData`=0xFFFF_FFEB.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE.
- MULHSU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV rs1=0xFFFF_FFF9 (−7), rs2=2 → 0xFFFF_FFFD.
- REM of the same operands → 0xFFFF_FFFF.
- DIVU 0x1234/0 → 0xFFFF_FFFF, and REMU 0x1234/0 → 0x1234:
  - Stall for 1 cycle only.
  - Valid on the next cycle.
- DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000; REM of the same → 0 (fast path).
- Flush and reset:
  - `EX_Flush` at A+10: no `EX_MdValid`; stall drops at A+11.
  - A new DIVU 100/7 accepted at A+11 → 14 after 33 more cycles.
  - `rst_n` low at A+5 → IDLE, outputs 0.
